// File: rtl/immed_fetch_arbiter_if.sv
// immed_fetch_arbiter_if: requester, FIFO and status signals of the immediate-fetch arbiter.
// Rev 1.0 -- slave side is the arbiter, master side is its environment.
`default_nettype none

interface immed_fetch_arbiter_if;
  logic        disp_start;
  logic        disp_is_8bit;
  logic        disp_complete;
  logic        imm_start;
  logic        imm_is_8bit;
  logic        imm_complete;
  logic [15:0] immediate;
  logic        modrm_fifo_rd_en;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        flush;
  logic        busy;

  modport slave (
    input  disp_start, disp_is_8bit, imm_start, imm_is_8bit,
    input  modrm_fifo_rd_en, fifo_rd_data, fifo_empty, flush,
    output disp_complete, imm_complete, immediate, fifo_rd_en, busy
  );

  modport master (
    output disp_start, disp_is_8bit, imm_start, imm_is_8bit,
    output modrm_fifo_rd_en, fifo_rd_data, fifo_empty, flush,
    input  disp_complete, imm_complete, immediate, fifo_rd_en, busy
  );
endinterface

`default_nettype wire

// File: rtl/immed_fetch_arbiter.sv
// immed_fetch_arbiter: one immediate-fetch engine shared by the ModRM (displacement) and
// opcode (immediate) decoders; pulls 1/2 LE bytes from the FIFO. Rev 1.0
`default_nettype none

module immed_fetch_arbiter #(
  parameter bit DISP_SEXT = 1'b1,
  parameter bit IMM_SEXT  = 1'b1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  immed_fetch_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_LATCH_LO = 3'd2,
    S_FETCH_HI = 3'd3,
    S_LATCH_HI = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        owner_imm_q, owner_imm_d;
  logic        is_8bit_q, is_8bit_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] immediate_q, immediate_d;
  logic        disp_complete_q, disp_complete_d;
  logic        imm_complete_q, imm_complete_d;
  logic        busy_q, busy_d;
  logic        eng_rd;
  logic        sext_sel;
  logic        ext_bit;

  assign sext_sel = owner_imm_q ? IMM_SEXT : DISP_SEXT;
  assign ext_bit  = bus.fifo_rd_data[7] & sext_sel;

  always_comb begin
    state_d         = state_q;
    owner_imm_d     = owner_imm_q;
    is_8bit_d       = is_8bit_q;
    lo_d            = lo_q;
    immediate_d     = immediate_q;
    disp_complete_d = 1'b0;
    imm_complete_d  = 1'b0;
    eng_rd          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.disp_start) begin
          owner_imm_d = 1'b0;
          is_8bit_d   = bus.disp_is_8bit;
          state_d     = S_FETCH_LO;
        end else if (bus.imm_start) begin
          owner_imm_d = 1'b1;
          is_8bit_d   = bus.imm_is_8bit;
          state_d     = S_FETCH_LO;
        end
      end
      S_FETCH_LO: begin
        // The ModRM decoder's own pop always owns the port in a contended cycle.
        eng_rd = ~bus.fifo_empty & ~bus.modrm_fifo_rd_en & ~bus.flush;
        if (eng_rd) state_d = S_LATCH_LO;
      end
      S_LATCH_LO: begin
        lo_d = bus.fifo_rd_data;
        if (is_8bit_q) begin
          immediate_d     = {{8{ext_bit}}, bus.fifo_rd_data};
          disp_complete_d = ~owner_imm_q;
          imm_complete_d  = owner_imm_q;
          state_d         = S_DONE;
        end else begin
          state_d = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        eng_rd = ~bus.fifo_empty & ~bus.modrm_fifo_rd_en & ~bus.flush;
        if (eng_rd) state_d = S_LATCH_HI;
      end
      S_LATCH_HI: begin
        immediate_d     = {bus.fifo_rd_data, lo_q};
        disp_complete_d = ~owner_imm_q;
        imm_complete_d  = owner_imm_q;
        state_d         = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a fresh request in IDLE.
    if (bus.flush) begin
      state_d         = S_IDLE;
      lo_d            = lo_q;
      immediate_d     = immediate_q;
      disp_complete_d = 1'b0;
      imm_complete_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      owner_imm_q     <= 1'b0;
      is_8bit_q       <= 1'b0;
      lo_q            <= 8'h00;
      immediate_q     <= 16'h0000;
      disp_complete_q <= 1'b0;
      imm_complete_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_imm_q     <= owner_imm_d;
      is_8bit_q       <= is_8bit_d;
      lo_q            <= lo_d;
      immediate_q     <= immediate_d;
      disp_complete_q <= disp_complete_d;
      imm_complete_q  <= imm_complete_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.fifo_rd_en    = ~reset & (bus.modrm_fifo_rd_en | eng_rd);
  assign bus.immediate     = immediate_q;
  assign bus.disp_complete = disp_complete_q;
  assign bus.imm_complete  = imm_complete_q;
  assign bus.busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_immed_fetch_arbiter.sv
// tb_immed_fetch_arbiter: directed vectors with a completion scoreboard and a byte-queue FIFO model.
`default_nettype none

module tb_immed_fetch_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  immed_fetch_arbiter_if bus();

  immed_fetch_arbiter #(.DISP_SEXT(1'b1), .IMM_SEXT(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    bit          owner_imm;
    logic [15:0] value;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         pops   = 0;
  logic       pend   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // FIFO model: pop decided from the stable mid-cycle value, data valid next cycle.
  initial begin
    bus.fifo_rd_data = 8'h00;
    bus.fifo_empty   = 1'b1;
    forever begin
      @(negedge clk);
      pend = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (pend) begin
        pops++;
        if (fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
      end
      bus.fifo_empty = (fq.size() == 0);
    end
  end

  // Monitor: checks every completion against the scoreboard and every pop for legality.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.fifo_rd_en)
        chk("pop_on_empty", {31'd0, bus.fifo_empty & ~bus.modrm_fifo_rd_en}, 32'd0);
      if (bus.disp_complete || bus.imm_complete) begin
        if (bus.disp_complete && bus.imm_complete) begin
          chk("both_complete", 32'd1, 32'd0);
        end else if (sb.size() == 0) begin
          chk("unexpected_complete", {31'd0, bus.imm_complete}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("owner_imm", {31'd0, bus.imm_complete}, {31'd0, e.owner_imm});
          chk("immediate", {16'd0, bus.immediate}, {16'd0, e.value});
          chk("complete_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmp(input bit owner_imm, input string name);
    int n;
    n = 0;
    while (!(owner_imm ? bus.imm_complete : bus.disp_complete) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_complete required=complete", name);
    end
  endtask

  task automatic single(input bit owner_imm, input bit is8, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [15:0] expv, input string name);
    int p0;
    p0 = pops;
    fq.push_back(b0);
    if (!is8) fq.push_back(b1);
    bus.fifo_empty = 1'b0;
    sb.push_back('{owner_imm, expv, cyc + (is8 ? 3 : 5)});
    if (owner_imm) begin
      bus.imm_start   = 1'b1;
      bus.imm_is_8bit = is8;
    end else begin
      bus.disp_start   = 1'b1;
      bus.disp_is_8bit = is8;
    end
    wait_cmp(owner_imm, name);
    tick();
    bus.disp_start = 1'b0;
    bus.imm_start  = 1'b0;
    chk({name, "_pops"}, pops - p0, is8 ? 32'd1 : 32'd2);
    tick();
  endtask

  initial begin
    int p0;
    int c;
    bus.disp_start       = 1'b0;
    bus.disp_is_8bit     = 1'b0;
    bus.imm_start        = 1'b0;
    bus.imm_is_8bit      = 1'b0;
    bus.modrm_fifo_rd_en = 1'b0;
    bus.flush            = 1'b0;
    tick();
    tick();
    chk("rst_immediate", {16'd0, bus.immediate}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_disp_complete", {31'd0, bus.disp_complete}, 32'd0);
    chk("rst_imm_complete", {31'd0, bus.imm_complete}, 32'd0);
    chk("rst_fifo_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    single(1'b0, 1'b1, 8'hF0, 8'h00, 16'hFFF0, "disp8_sext");
    single(1'b1, 1'b0, 8'h34, 8'h12, 16'h1234, "imm16");

    // Simultaneous requests: displacement served first, immediate right after.
    c  = cyc;
    p0 = pops;
    fq.push_back(8'h05); fq.push_back(8'hEF); fq.push_back(8'hBE);
    bus.fifo_empty = 1'b0;
    sb.push_back('{1'b0, 16'h0005, c + 3});
    sb.push_back('{1'b1, 16'hBEEF, c + 9});
    bus.disp_start = 1'b1; bus.disp_is_8bit = 1'b1;
    bus.imm_start  = 1'b1; bus.imm_is_8bit  = 1'b0;
    wait_cmp(1'b0, "both_disp");
    tick();
    bus.disp_start = 1'b0;
    wait_cmp(1'b1, "both_imm");
    tick();
    bus.imm_start = 1'b0;
    chk("both_pops", pops - p0, 32'd3);
    tick();

    // Contention: one ModRM pop in FETCH_LO, four empty cycles in FETCH_HI.
    c  = cyc;
    p0 = pops;
    fq.push_back(8'hAA); fq.push_back(8'h78);
    bus.fifo_empty = 1'b0;
    sb.push_back('{1'b1, 16'h5678, c + 10});
    bus.imm_start = 1'b1; bus.imm_is_8bit = 1'b0;
    tick();
    bus.modrm_fifo_rd_en = 1'b1;
    tick();
    bus.modrm_fifo_rd_en = 1'b0;
    repeat (6) tick();
    chk("stall_busy", {31'd0, bus.busy}, 32'd1);
    fq.push_back(8'h56);
    bus.fifo_empty = 1'b0;
    wait_cmp(1'b1, "contend");
    tick();
    bus.imm_start = 1'b0;
    chk("contend_pops", pops - p0, 32'd3);
    tick();

    // Flush during LATCH_LO of a 16-bit fetch.
    p0 = pops;
    fq.push_back(8'h11); fq.push_back(8'h22);
    bus.fifo_empty = 1'b0;
    bus.imm_start = 1'b1; bus.imm_is_8bit = 1'b0;
    tick();
    tick();
    bus.flush     = 1'b1;
    bus.imm_start = 1'b0;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_immediate", {16'd0, bus.immediate}, 32'h5678);
    tick();
    tick();
    chk("flush_pops", pops - p0, 32'd1);
    fq.delete();
    bus.fifo_empty = 1'b1;
    tick();

    // Reset in the middle of FETCH_HI.
    p0 = pops;
    fq.push_back(8'h9A); fq.push_back(8'hBC);
    bus.fifo_empty = 1'b0;
    bus.imm_start = 1'b1; bus.imm_is_8bit = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_fifo_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_immediate", {16'd0, bus.immediate}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_fifo_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("mid_rst_complete", {30'd0, bus.disp_complete, bus.imm_complete}, 32'd0);
    bus.imm_start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pops", pops - p0, 32'd1);
    fq.delete();
    bus.fifo_empty = 1'b1;
    tick();

    single(1'b1, 1'b1, 8'h80, 8'h00, 16'hFF80, "imm8_sext");
    single(1'b0, 1'b0, 8'h7F, 8'h80, 16'h807F, "disp16");

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
